// File: rtl/demux_1x4_sched_if.sv
// Stream bundle for demux_1x4_sched: one valid/ready input stream, four output lanes.
// The master modport drives the producer/consumer side; the slave modport is the dispatcher.
interface demux_1x4_sched_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0]      in_data;
    logic [1:0]            in_dest;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][WIDTH-1:0] outp;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [1:0]            sel;
    logic                  busy;

    modport master (
        output in_data,
        output in_dest,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  outp,
        input  out_valid,
        input  sel,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_dest,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output outp,
        output out_valid,
        output sel,
        output busy
    );
endinterface

// File: rtl/demux_1x4_sched.sv
// Single-entry stream dispatcher routing each word to one of four lanes (round-robin or tagged).
// Optional per-lane fire counters and stall counter when DEMUX_SCHED_STATS_EN is defined.
module demux_1x4_sched #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
`ifdef DEMUX_SCHED_STATS_EN
    output logic [3:0][15:0]      lane_count,
    output logic [15:0]           stall_count,
`endif
    demux_1x4_sched_if.slave      bus
);

    logic             buf_valid_q, buf_valid_d;
    logic [WIDTH-1:0] buf_data_q, buf_data_d;
    logic [1:0]       buf_dest_q, buf_dest_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic [1:0] tgt;
    logic       fire;
    logic       accept;
    logic       in_ready;

    assign tgt      = (ROUTE_MODE == 1) ? buf_dest_q : rr_ptr_q;
    assign fire     = buf_valid_q && bus.out_ready[tgt];
    // Ready passes straight through from the target lane so a draining buffer refills same cycle.
    assign in_ready = !rst && !flush && (!buf_valid_q || fire);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready = in_ready;
    assign bus.sel      = tgt;
    assign bus.busy     = buf_valid_q;

    always_comb begin
        bus.outp      = '0;
        bus.out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            if (buf_valid_q && (tgt == 2'(k))) begin
                bus.outp[k]      = buf_data_q;
                bus.out_valid[k] = 1'b1;
            end
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_dest_d  = buf_dest_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            buf_valid_d = 1'b0;
            rr_ptr_d    = 2'd0;
        end else begin
            if (accept) begin
                buf_valid_d = 1'b1;
                buf_data_d  = bus.in_data;
                buf_dest_d  = bus.in_dest;
            end else if (fire) begin
                buf_valid_d = 1'b0;
            end
            if (fire && (ROUTE_MODE == 0)) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_dest_q  <= 2'd0;
            rr_ptr_q    <= 2'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_dest_q  <= buf_dest_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef DEMUX_SCHED_STATS_EN
    logic [3:0][15:0] lane_count_q, lane_count_d;
    logic [15:0]      stall_count_q, stall_count_d;
    logic             stall;

    assign stall = buf_valid_q && !bus.out_ready[tgt];

    always_comb begin
        lane_count_d  = lane_count_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            lane_count_d  = '0;
            stall_count_d = '0;
        end else begin
            if (fire && (lane_count_q[tgt] != 16'hFFFF)) begin
                lane_count_d[tgt] = lane_count_q[tgt] + 16'd1;
            end
            if (stall && (stall_count_q != 16'hFFFF)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            lane_count_q  <= lane_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign lane_count  = lane_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_demux_1x4_sched.sv
// Directed self-checking bench for demux_1x4_sched: one round-robin and one tag-routed instance.
module tb_demux_1x4_sched;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_1x4_sched_if #(.WIDTH(WIDTH)) bus_rr ();
    demux_1x4_sched_if #(.WIDTH(WIDTH)) bus_tg ();

`ifdef DEMUX_SCHED_STATS_EN
    logic [3:0][15:0] lane_count_rr, lane_count_tg;
    logic [15:0]      stall_count_rr, stall_count_tg;
`endif

    demux_1x4_sched #(.WIDTH(WIDTH), .ROUTE_MODE(0)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
`ifdef DEMUX_SCHED_STATS_EN
        .lane_count  (lane_count_rr),
        .stall_count (stall_count_rr),
`endif
        .bus         (bus_rr.slave)
    );

    demux_1x4_sched #(.WIDTH(WIDTH), .ROUTE_MODE(1)) u_tg (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
`ifdef DEMUX_SCHED_STATS_EN
        .lane_count  (lane_count_tg),
        .stall_count (stall_count_tg),
`endif
        .bus         (bus_tg.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lane_vec(input int lane, input logic [15:0] data);
        logic [63:0] v;
        v = 64'(data);
        return v << (16 * lane);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_rr.in_data   = '0;
        bus_rr.in_dest   = '0;
        bus_rr.in_valid  = 1'b0;
        bus_rr.out_ready = 4'h0;
        bus_tg.in_data   = '0;
        bus_tg.in_dest   = '0;
        bus_tg.in_valid  = 1'b0;
        bus_tg.out_ready = 4'h0;

        // Reset state
        step();
        step();
        check_eq("rst_out_valid", 64'(bus_rr.out_valid), 64'h0);
        check_eq("rst_outp", 64'(bus_rr.outp), 64'h0);
        check_eq("rst_sel", 64'(bus_rr.sel), 64'h0);
        check_eq("rst_busy", 64'(bus_rr.busy), 64'h0);
        bus_rr.in_valid = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(bus_rr.in_ready), 64'h0);

        // Round-robin streaming at full rate
        rst = 1'b0;
        bus_rr.out_ready = 4'hF;
        bus_rr.in_data = 16'hA0;
        #1;
        check_eq("rr_in_ready_idle", 64'(bus_rr.in_ready), 64'h1);
        for (int i = 0; i < 8; i++) begin
            bus_rr.in_data = 16'(16'hA0 + i);
            step();
            check_eq("rr_out_valid", 64'(bus_rr.out_valid), 64'(4'b0001 << (i % 4)));
            check_eq("rr_outp", 64'(bus_rr.outp), lane_vec(i % 4, 16'(16'hA0 + i)));
            check_eq("rr_sel", 64'(bus_rr.sel), 64'(i % 4));
            check_eq("rr_in_ready", 64'(bus_rr.in_ready), 64'h1);
        end
        bus_rr.in_valid = 1'b0;
        step();
        check_eq("rr_drain_busy", 64'(bus_rr.busy), 64'h0);
        check_eq("rr_drain_out_valid", 64'(bus_rr.out_valid), 64'h0);
        check_eq("rr_drain_sel", 64'(bus_rr.sel), 64'h0);
`ifdef DEMUX_SCHED_STATS_EN
        for (int k = 0; k < 4; k++) begin
            check_eq("stats_lane_count", 64'(lane_count_rr[k]), 64'd2);
        end
        check_eq("stats_stall_zero", 64'(stall_count_rr), 64'd0);
`endif

        // Backpressure on lane 1
        bus_rr.in_valid = 1'b1;
        bus_rr.in_data = 16'hB0;
        step();
        bus_rr.in_data = 16'hB1;
        bus_rr.out_ready = 4'b1101;
        step();
        bus_rr.in_data = 16'hB2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_out_valid", 64'(bus_rr.out_valid), 64'h2);
            check_eq("bp_outp", 64'(bus_rr.outp), lane_vec(1, 16'hB1));
            check_eq("bp_in_ready", 64'(bus_rr.in_ready), 64'h0);
            check_eq("bp_sel", 64'(bus_rr.sel), 64'h1);
            step();
        end
        bus_rr.out_ready = 4'hF;
        #1;
        check_eq("bp_release_ready", 64'(bus_rr.in_ready), 64'h1);
        step();
        check_eq("bp_next_lane", 64'(bus_rr.out_valid), 64'h4);
        check_eq("bp_next_outp", 64'(bus_rr.outp), lane_vec(2, 16'hB2));
        bus_rr.in_valid = 1'b0;
        step();

        // Flush with a word held on lane 2
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus_rr.in_valid = 1'b1;
        bus_rr.in_data = 16'hC0;
        step();
        bus_rr.in_data = 16'hC1;
        step();
        bus_rr.in_data = 16'hC2;
        bus_rr.out_ready = 4'b1011;
        step();
        check_eq("fl_held_lane2", 64'(bus_rr.outp), lane_vec(2, 16'hC2));
        bus_rr.in_data = 16'hC9;
        flush = 1'b1;
        #1;
        check_eq("fl_in_ready", 64'(bus_rr.in_ready), 64'h0);
        step();
        flush = 1'b0;
        bus_rr.in_valid = 1'b0;
        #1;
        check_eq("fl_busy", 64'(bus_rr.busy), 64'h0);
        check_eq("fl_out_valid", 64'(bus_rr.out_valid), 64'h0);
        check_eq("fl_sel", 64'(bus_rr.sel), 64'h0);
        bus_rr.in_valid = 1'b1;
        bus_rr.in_data = 16'hCA;
        bus_rr.out_ready = 4'hF;
        step();
        check_eq("fl_after_lane0", 64'(bus_rr.outp), lane_vec(0, 16'hCA));
        check_eq("fl_after_valid", 64'(bus_rr.out_valid), 64'h1);
        bus_rr.in_valid = 1'b0;
        step();

        // Mid-stream reset with lane 3 stalled
        bus_rr.in_valid = 1'b1;
        bus_rr.in_data = 16'hD1;
        step();
        bus_rr.in_data = 16'hD2;
        step();
        bus_rr.in_data = 16'hDD;
        bus_rr.out_ready = 4'b0111;
        step();
        bus_rr.in_valid = 1'b0;
        step();
        check_eq("mr_held_valid", 64'(bus_rr.out_valid), 64'h8);
        check_eq("mr_held_outp", 64'(bus_rr.outp), lane_vec(3, 16'hDD));
        rst = 1'b1;
        bus_rr.in_valid = 1'b1;
        bus_rr.in_data = 16'hEE;
        #1;
        check_eq("mr_in_ready_rst", 64'(bus_rr.in_ready), 64'h0);
        step();
        check_eq("mr_out_valid", 64'(bus_rr.out_valid), 64'h0);
        check_eq("mr_outp", 64'(bus_rr.outp), 64'h0);
        check_eq("mr_sel", 64'(bus_rr.sel), 64'h0);
        check_eq("mr_busy", 64'(bus_rr.busy), 64'h0);
        check_eq("mr_in_ready", 64'(bus_rr.in_ready), 64'h0);
`ifdef DEMUX_SCHED_STATS_EN
        for (int k = 0; k < 4; k++) begin
            check_eq("stats_lane_clear", 64'(lane_count_rr[k]), 64'd0);
        end
        check_eq("stats_stall_clear", 64'(stall_count_rr), 64'd0);
`endif
        rst = 1'b0;
        bus_rr.in_data = 16'hE0;
        bus_rr.out_ready = 4'hF;
        step();
        check_eq("mr_next_lane0", 64'(bus_rr.outp), lane_vec(0, 16'hE0));
        bus_rr.in_valid = 1'b0;
        step();

        // Tag-routed instance
        bus_tg.out_ready = 4'hF;
        bus_tg.in_valid = 1'b1;
        bus_tg.in_data = 16'h11;
        bus_tg.in_dest = 2'd3;
        step();
        check_eq("tg_valid_1", 64'(bus_tg.out_valid), 64'h8);
        check_eq("tg_outp_1", 64'(bus_tg.outp), lane_vec(3, 16'h11));
        check_eq("tg_sel_1", 64'(bus_tg.sel), 64'h3);
        bus_tg.in_data = 16'h22;
        bus_tg.in_dest = 2'd3;
        step();
        check_eq("tg_valid_2", 64'(bus_tg.out_valid), 64'h8);
        check_eq("tg_outp_2", 64'(bus_tg.outp), lane_vec(3, 16'h22));
        bus_tg.in_data = 16'h33;
        bus_tg.in_dest = 2'd0;
        step();
        check_eq("tg_valid_3", 64'(bus_tg.out_valid), 64'h1);
        check_eq("tg_outp_3", 64'(bus_tg.outp), lane_vec(0, 16'h33));
        check_eq("tg_sel_3", 64'(bus_tg.sel), 64'h0);
        bus_tg.in_valid = 1'b0;
        step();
        check_eq("tg_drain_busy", 64'(bus_tg.busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
